// File: rtl/eco32f_fetch_pkg.sv
// Shared definitions for the eco32f instruction fetch stage: state encodings,
// reset PC, NOP encoding and the PC increment helper.
package eco32f_fetch_pkg;

    typedef enum logic [2:0] {
        ECO32F_IF_IDLE    = 3'd0,
        ECO32F_IF_FETCH   = 3'd1,
        ECO32F_IF_HOLD    = 3'd2,
        ECO32F_IF_DISCARD = 3'd3,
        ECO32F_IF_FAULT   = 3'd4
    } if_state_e;

    localparam logic [31:0] ECO32F_NOP_INSN = 32'h0000_0000;
    localparam logic [31:0] ECO32F_RESET_PC = 32'hE000_0000;

    // Sequential fetch wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/eco32f_fetch_skid.sv
// One-entry {pc, insn, fault} buffer that parks a bus response while the
// consumer is stalled.
module eco32f_fetch_skid
    import eco32f_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_insn,
    input  logic        load_fault,
    output logic        valid,
    output logic [31:0] skid_pc,
    output logic [31:0] skid_insn,
    output logic        skid_fault
);

    always_ff @(posedge clk) begin
        if (!rst)
            valid <= 1'b0;
        else if (clear || unload)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            skid_pc    <= load_pc;
            skid_insn  <= load_insn;
            skid_fault <= load_fault;
        end
    end

endmodule

// File: rtl/eco32f_fetch.sv
// Instruction fetch stage: PC, request/ack bus handshake, skid buffer for
// stalled responses and redirect squashing of in-flight fetches.
module eco32f_fetch
    import eco32f_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ECO32F_RESET_PC,
    parameter logic [31:0] NOP_INSN = ECO32F_NOP_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        if_redirect,
    input  logic [31:0] if_redirect_pc,
    output logic        ibus_req,
    output logic [31:0] ibus_adr,
    input  logic        ibus_ack,
    input  logic        ibus_err,
    input  logic [31:0] ibus_dat,
    output logic [31:0] id_pc,
    output logic [31:0] id_insn,
    output logic        id_exc_ibus_fault,
    output logic        id_valid
);

    if_state_e   state, state_n;
    logic [31:0] pc, pc_n, adr_n, redirect_pc;
    logic [31:0] id_pc_n, id_insn_n;
    logic        id_fault_n, id_valid_n, req_n, resp;
    logic        skid_load, skid_unload, skid_clear;
    logic        skid_valid, skid_fault;
    logic [31:0] skid_pc, skid_insn, resp_insn;

    assign redirect_pc = if_redirect_pc & ~32'h3;
    assign resp        = ibus_ack | ibus_err;
    assign resp_insn   = ibus_ack ? ibus_dat : NOP_INSN;

    eco32f_fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_pc    (pc),
        .load_insn  (resp_insn),
        .load_fault (ibus_err),
        .valid      (skid_valid),
        .skid_pc    (skid_pc),
        .skid_insn  (skid_insn),
        .skid_fault (skid_fault)
    );

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        id_pc_n     = id_pc;
        id_insn_n   = id_insn;
        id_fault_n  = id_exc_ibus_fault;
        id_valid_n  = id_valid;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (if_redirect) begin
            // Squash wins over stall; any response this cycle is dropped.
            pc_n        = redirect_pc;
            id_insn_n   = NOP_INSN;
            id_fault_n  = 1'b0;
            id_valid_n  = 1'b0;
            skid_clear  = 1'b1;
            if (state == ECO32F_IF_DISCARD && !resp)
                state_n = ECO32F_IF_DISCARD;
            else if (ibus_req && !resp)
                state_n = ECO32F_IF_DISCARD;
            else
                state_n = ECO32F_IF_FETCH;
        end else begin
            case (state)
                ECO32F_IF_IDLE: state_n = ECO32F_IF_FETCH;
                ECO32F_IF_FETCH: begin
                    if (resp) begin
                        if (ibus_ack)
                            pc_n = pc_inc(pc);
                        if (id_stall) begin
                            skid_load = 1'b1;
                            state_n   = ECO32F_IF_HOLD;
                        end else begin
                            id_pc_n    = pc;
                            id_insn_n  = resp_insn;
                            id_fault_n = ibus_err;
                            id_valid_n = 1'b1;
                            state_n    = ibus_err ? ECO32F_IF_FAULT : ECO32F_IF_FETCH;
                        end
                    end else if (!id_stall) begin
                        id_insn_n  = NOP_INSN;
                        id_fault_n = 1'b0;
                        id_valid_n = 1'b0;
                    end
                end
                ECO32F_IF_HOLD: begin
                    if (!id_stall) begin
                        id_pc_n     = skid_pc;
                        id_insn_n   = skid_insn;
                        id_fault_n  = skid_fault;
                        id_valid_n  = skid_valid;
                        skid_unload = 1'b1;
                        state_n     = skid_fault ? ECO32F_IF_FAULT : ECO32F_IF_FETCH;
                    end
                end
                ECO32F_IF_DISCARD, ECO32F_IF_FAULT: begin
                    if (!id_stall) begin
                        id_insn_n  = NOP_INSN;
                        id_fault_n = 1'b0;
                        id_valid_n = 1'b0;
                    end
                    if (state == ECO32F_IF_DISCARD && resp)
                        state_n = ECO32F_IF_FETCH;
                end
                default: state_n = ECO32F_IF_IDLE;
            endcase
        end

        // Bus outputs are registered; the address only moves when a fresh
        // request is about to be issued, so it is stable while req is high.
        req_n = (state_n == ECO32F_IF_FETCH) || (state_n == ECO32F_IF_DISCARD);
        adr_n = (state_n == ECO32F_IF_FETCH) ? pc_n : ibus_adr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= ECO32F_IF_IDLE;
            pc                <= RESET_PC;
            ibus_req          <= 1'b0;
            ibus_adr          <= RESET_PC;
            id_pc             <= RESET_PC;
            id_insn           <= NOP_INSN;
            id_exc_ibus_fault <= 1'b0;
            id_valid          <= 1'b0;
        end else begin
            state             <= state_n;
            pc                <= pc_n;
            ibus_req          <= req_n;
            ibus_adr          <= adr_n;
            id_pc             <= id_pc_n;
            id_insn           <= id_insn_n;
            id_exc_ibus_fault <= id_fault_n;
            id_valid          <= id_valid_n;
        end
    end

endmodule

// File: tb/tb_eco32f_fetch.sv
// Directed bench for eco32f_fetch: a vector table for the streaming, stall and
// fault paths, then hand sequences for discard, squash, wrap and reset.
module tb_eco32f_fetch;

    localparam logic [31:0] B = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_stall = 1'b0;
    logic        if_redirect = 1'b0;
    logic [31:0] if_redirect_pc = '0;
    logic        ibus_req;
    logic [31:0] ibus_adr;
    logic        ibus_ack = 1'b0;
    logic        ibus_err = 1'b0;
    logic [31:0] ibus_dat = '0;
    logic [31:0] id_pc, id_insn;
    logic        id_exc_ibus_fault, id_valid;

    int total = 0;
    int bad   = 0;

    eco32f_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .id_stall          (id_stall),
        .if_redirect       (if_redirect),
        .if_redirect_pc    (if_redirect_pc),
        .ibus_req          (ibus_req),
        .ibus_adr          (ibus_adr),
        .ibus_ack          (ibus_ack),
        .ibus_err          (ibus_err),
        .ibus_dat          (ibus_dat),
        .id_pc             (id_pc),
        .id_insn           (id_insn),
        .id_exc_ibus_fault (id_exc_ibus_fault),
        .id_valid          (id_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn, stall, redir;
        logic [31:0] rpc;
        logic        ack, err;
        logic [31:0] dat;
        logic        req;
        logic [31:0] adr, pc, insn;
        logic        flt, vld;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] x(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic vec_t mk(input logic rstn, stall, redir, input logic [31:0] rpc,
                                input logic ack, err, input logic [31:0] dat,
                                input logic req, input logic [31:0] adr, pc, insn,
                                input logic flt, vld);
        vec_t v;
        v.rstn = rstn; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.ack = ack; v.err = err; v.dat = dat;
        v.req = req; v.adr = adr; v.pc = pc; v.insn = insn; v.flt = flt; v.vld = vld;
        return v;
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h exp=%h", name, field, got, exp);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        rst            = v.rstn;
        id_stall       = v.stall;
        if_redirect    = v.redir;
        if_redirect_pc = v.rpc;
        ibus_ack       = v.ack;
        ibus_err       = v.err;
        ibus_dat       = v.dat;
        @(posedge clk);
        #1;
        chk(name, "ibus_req", {31'b0, ibus_req}, {31'b0, v.req});
        chk(name, "ibus_adr", ibus_adr, v.adr);
        chk(name, "id_pc", id_pc, v.pc);
        chk(name, "id_insn", id_insn, v.insn);
        chk(name, "id_fault", {31'b0, id_exc_ibus_fault}, {31'b0, v.flt});
        chk(name, "id_valid", {31'b0, id_valid}, {31'b0, v.vld});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit exceeded");
        $fatal(1);
    end

    initial begin
        // rstn stall redir rpc | ack err dat | req adr pc insn flt vld
        tbl.push_back(mk(0,0,0,0, 0,0,0,            0, B,       B,       32'h0,     0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,            1, B,       B,       32'h0,     0,0));
        tbl.push_back(mk(1,0,0,0, 1,0,x(B),         1, B+4,     B,       x(B),      0,1));
        tbl.push_back(mk(1,0,0,0, 1,0,x(B+4),       1, B+8,     B+4,     x(B+4),    0,1));
        tbl.push_back(mk(1,1,0,0, 1,0,x(B+8),       0, B+8,     B+4,     x(B+4),    0,1));
        tbl.push_back(mk(1,1,0,0, 0,0,0,            0, B+8,     B+4,     x(B+4),    0,1));
        tbl.push_back(mk(1,1,0,0, 0,0,0,            0, B+8,     B+4,     x(B+4),    0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,            1, B+'hC,   B+8,     x(B+8),    0,1));
        tbl.push_back(mk(1,0,0,0, 1,0,x(B+'hC),     1, B+'h10,  B+'hC,   x(B+'hC),  0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,            1, B+'h10,  B+'hC,   32'h0,     0,0));
        tbl.push_back(mk(1,0,0,0, 1,0,x(B+'h10),    1, B+'h14,  B+'h10,  x(B+'h10), 0,1));
        tbl.push_back(mk(1,0,0,0, 1,0,x(B+'h14),    1, B+'h18,  B+'h14,  x(B+'h14), 0,1));
        tbl.push_back(mk(1,0,0,0, 1,0,x(B+'h18),    1, B+'h1C,  B+'h18,  x(B+'h18), 0,1));
        tbl.push_back(mk(1,0,0,0, 1,0,x(B+'h1C),    1, B+'h20,  B+'h1C,  x(B+'h1C), 0,1));
        tbl.push_back(mk(1,0,0,0, 0,1,32'h1111_1111,0, B+'h20,  B+'h20,  32'h0,     1,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,            0, B+'h20,  B+'h20,  32'h0,     0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,            0, B+'h20,  B+'h20,  32'h0,     0,0));
        tbl.push_back(mk(1,0,1,32'h203, 0,0,0,      1, 32'h200, B+'h20,  32'h0,     0,0));
        tbl.push_back(mk(1,0,0,0, 1,0,x(32'h200),   1, 32'h204, 32'h200, x(32'h200),0,1));
        tbl.push_back(mk(1,1,0,0, 0,1,32'h2222_2222,0, 32'h204, 32'h200, x(32'h200),0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,            0, 32'h204, 32'h204, 32'h0,     1,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0,            0, 32'h204, 32'h204, 32'h0,     0,0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Redirect while a request is pending and its ack arrives late.
        step(mk(1,0,1,B+'h10, 0,0,0,              1, B+'h10,      32'h204, 32'h0, 0,0), "disc_arm");
        step(mk(1,0,1,32'h1000, 0,0,0,            1, B+'h10,      32'h204, 32'h0, 0,0), "disc_redir");
        step(mk(1,0,0,0, 0,0,0,                   1, B+'h10,      32'h204, 32'h0, 0,0), "disc_wait1");
        step(mk(1,0,0,0, 0,0,0,                   1, B+'h10,      32'h204, 32'h0, 0,0), "disc_wait2");
        step(mk(1,0,0,0, 1,0,32'hDEAD_BEEF,       1, 32'h1000,    32'h204, 32'h0, 0,0), "disc_drop");
        step(mk(1,0,0,0, 1,0,x(32'h1000),         1, 32'h1004,    32'h1000, x(32'h1000), 0,1), "disc_resume");

        // Redirect and ack together under stall: data dropped, slot squashed.
        step(mk(1,1,1,32'h2000, 1,0,32'h1234_5678, 1, 32'h2000,   32'h1000, 32'h0, 0,0), "sq_stall");
        step(mk(1,0,0,0, 1,0,x(32'h2000),         1, 32'h2004,    32'h2000, x(32'h2000), 0,1), "sq_resume");

        // PC wrap at the top of the address space.
        step(mk(1,0,1,32'hFFFF_FFFC, 1,0,32'h0BAD_0BAD, 1, 32'hFFFF_FFFC, 32'h2000, 32'h0, 0,0), "wrap_redir");
        step(mk(1,0,0,0, 1,0,x(32'hFFFF_FFFC),    1, 32'h0,       32'hFFFF_FFFC, x(32'hFFFF_FFFC), 0,1), "wrap");

        // Reset in the middle of an outstanding request.
        step(mk(0,0,0,0, 0,0,0,                   0, B,           B, 32'h0, 0,0), "rst_mid");
        step(mk(1,0,0,0, 1,0,32'h0BAD_F00D,       1, B,           B, 32'h0, 0,0), "rst_stray_ack");
        step(mk(1,0,0,0, 1,0,x(B),                1, B+4,         B, x(B), 0,1), "rst_resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eco32f_fetch.md
Name: eco32f_fetch

Overview:
Instruction fetch stage. Sits directly upstream of eco32f_decode and drives its id_pc, id_insn and id_exc_ibus_fault inputs. Keeps the program counter and runs a request/acknowledge handshake on the instruction bus. A one-entry skid buffer catches responses that return while decode is stalled, and branch/exception redirects squash in-flight fetches.

Parameters:
RESET_PC, 32'hE000_0000, PC loaded at reset (ROM start).
NOP_INSN, 32'h0000_0000, encoding driven on id_insn when no valid instruction is present (add $0,$0,$0).

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset synchronous and active-low
id_stall  in  1  decode stall; same signal that gates the decode output registers
if_redirect  in  1  branch taken / exception; squash and refetch
if_redirect_pc  in  32  redirect target, word aligned
ibus_req  out  1  instruction bus request
ibus_adr  out  32  request address
ibus_ack  in  1  read data valid
ibus_err  in  1  bus error, replaces ack
ibus_dat  in  32  read data
id_pc  out  32  PC of the instruction presented to decode
id_insn  out  32  instruction presented to decode
id_exc_ibus_fault  out  1  presented slot carries a bus fault
id_valid  out  1  presented slot is a real instruction

Behaviour:
- Bus rule: once ibus_req rises, ibus_req and ibus_adr stay constant until the cycle ibus_ack or ibus_err is sampled high. ack and err are never both high. After a response, a new request may start in the next cycle (back-to-back).
- Reset (rst==0 at edge):
  - state=IDLE, pc=RESET_PC, ibus_req=0, ibus_adr=RESET_PC.
  - id_pc=RESET_PC, id_insn=NOP_INSN, id_exc_ibus_fault=0, id_valid=0, skid buffer empty.
  - Reset mid-transaction abandons the request; the outstanding response is ignored because ibus_req=0.
- States: IDLE, FETCH, HOLD, DISCARD, FAULT.
- IDLE: go to FETCH the next cycle.
- FETCH: ibus_req=1, ibus_adr=pc.
  - ack with !id_stall: id_* <= {pc, ibus_dat, 0, valid 1}; pc += 4; stay in FETCH. Throughput is 1 insn/cycle with a zero-wait bus.
  - ack with id_stall: skid <= {pc, ibus_dat, fault 0}; pc += 4; id_* hold; go to HOLD with ibus_req=0.
  - err: same as ack, but with insn=NOP_INSN and fault=1. Target is FAULT, or HOLD→FAULT if stalled. pc does not advance.
  - No response, !id_stall: id_valid<=0, id_insn<=NOP_INSN, id_exc_ibus_fault<=0 (bubble).
  - No response, id_stall: id_* hold.
- HOLD: ibus_req=0. When !id_stall, id_* <= skid, skid cleared, go to FETCH (or FAULT if skid fault).
- FAULT: ibus_req=0. Fetching stops until if_redirect. When !id_stall, the slot after the faulting one is a bubble.
- DISCARD: ibus_req held at the old address. On ack/err the data is dropped and the state goes to FETCH at the new pc.
- Redirect (highest priority, overrides id_stall for the squash):
  - pc <= if_redirect_pc.
  - id_valid<=0, id_insn<=NOP_INSN, id_exc_ibus_fault<=0, skid cleared.
  - If a request is outstanding with no response this cycle, go to DISCARD; otherwise go to FETCH.
  - A response arriving in the redirect cycle is dropped.
  - A redirect while in DISCARD updates pc only.
- Arithmetic: pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). if_redirect_pc[1:0] is ignored and forced to 00.
- id_* are registered and change only on a clock edge. ibus_req and ibus_adr are registered outputs.

Decomposition:
- eco32f.vh additions: state encodings ECO32F_IF_IDLE/FETCH/HOLD/DISCARD/FAULT, ECO32F_NOP_INSN, ECO32F_RESET_PC.
- Sub-module eco32f_fetch_skid: one-entry {pc, insn, fault} buffer with load/unload/clear. This is natural and reusable for the data bus.

Test Plan:
- Reset release, ack every cycle, dat=addr^32'hA5A5_A5A5 → ibus_adr E000_0000, E000_0004, …; id_pc/id_insn follow 1 cycle later; id_valid=1 continuously.
- ack during a 3-cycle id_stall at pc E000_0008 → ibus_req drops, id_* frozen at E000_0004. After the stall, id_pc=E000_0008 from the skid, then E000_000C is fetched. No instruction lost or duplicated.
- if_redirect to 0000_1000 while a request to E000_0010 is pending with ack delayed 2 cycles → ibus_adr stays E000_0010 until ack. That data is never presented; the next request is 0000_1000; id_valid=0 in between.
- ibus_err at E000_0020 → id_exc_ibus_fault=1, id_insn=0, id_pc=E000_0020, then ibus_req stays 0. A redirect to 0000_0200 resumes fetch there.
- Redirect and ack in the same cycle, with id_stall=1 → the acked data is dropped, id_valid=0, and the next ibus_adr is the target.
- pc=FFFF_FFFC with ack → next ibus_adr=0000_0000; rst low mid-request → next cycle ibus_req=0 and id_pc=E000_0000.
